// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - runtime-reconfigurable VGA/DVI raster timing generator
module vga_timing_gen #(
  parameter int CW        = 11,
  parameter int DEF_HACT  = 640,
  parameter int DEF_HFP   = 16,
  parameter int DEF_HSYNC = 96,
  parameter int DEF_HBP   = 48,
  parameter int DEF_VACT  = 480,
  parameter int DEF_VFP   = 10,
  parameter int DEF_VSYNC = 2,
  parameter int DEF_VBP   = 33,
  parameter bit DEF_HPOL  = 1'b0,
  parameter bit DEF_VPOL  = 1'b0
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] cfg_hact,
  input  logic [CW-1:0] cfg_hfp,
  input  logic [CW-1:0] cfg_hsync,
  input  logic [CW-1:0] cfg_hbp,
  input  logic [CW-1:0] cfg_vact,
  input  logic [CW-1:0] cfg_vfp,
  input  logic [CW-1:0] cfg_vsync,
  input  logic [CW-1:0] cfg_vbp,
  input  logic          cfg_hpol,
  input  logic          cfg_vpol,
  input  logic          cfg_load,
  output logic          cfg_pending,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          de,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_start
);

  typedef struct packed {
    logic [CW-1:0] hact;
    logic [CW-1:0] hfp;
    logic [CW-1:0] hsync;
    logic [CW-1:0] hbp;
    logic [CW-1:0] vact;
    logic [CW-1:0] vfp;
    logic [CW-1:0] vsync;
    logic [CW-1:0] vbp;
    logic          hpol;
    logic          vpol;
  } timing_cfg_t;

  localparam timing_cfg_t DEF_CFG = '{
    hact:  CW'(DEF_HACT),
    hfp:   CW'(DEF_HFP),
    hsync: CW'(DEF_HSYNC),
    hbp:   CW'(DEF_HBP),
    vact:  CW'(DEF_VACT),
    vfp:   CW'(DEF_VFP),
    vsync: CW'(DEF_VSYNC),
    vbp:   CW'(DEF_VBP),
    hpol:  DEF_HPOL,
    vpol:  DEF_VPOL
  };

  localparam logic [CW:0] ONE = (CW+1)'(1);

  timing_cfg_t   act_cfg;
  timing_cfg_t   shd_cfg;
  timing_cfg_t   cfg_in;
  logic [CW-1:0] h;
  logic [CW-1:0] v;

  logic [CW:0] h_tot;
  logic [CW:0] v_tot;
  logic [CW:0] hs_beg;
  logic [CW:0] hs_end;
  logic [CW:0] vs_beg;
  logic [CW:0] vs_end;
  logic        h_last;
  logic        v_last;
  logic        hs_act;
  logic        vs_act;
  logic        blank_nx;
  logic        apply;

  assign cfg_in = '{
    hact:  cfg_hact,
    hfp:   cfg_hfp,
    hsync: cfg_hsync,
    hbp:   cfg_hbp,
    vact:  cfg_vact,
    vfp:   cfg_vfp,
    vsync: cfg_vsync,
    vbp:   cfg_vbp,
    hpol:  cfg_hpol,
    vpol:  cfg_vpol
  };

  // Sums carry one extra bit so a full 2^CW total still compares correctly.
  assign hs_beg = {1'b0, act_cfg.hact} + {1'b0, act_cfg.hfp};
  assign hs_end = hs_beg + {1'b0, act_cfg.hsync};
  assign h_tot  = hs_end + {1'b0, act_cfg.hbp};
  assign vs_beg = {1'b0, act_cfg.vact} + {1'b0, act_cfg.vfp};
  assign vs_end = vs_beg + {1'b0, act_cfg.vsync};
  assign v_tot  = vs_end + {1'b0, act_cfg.vbp};

  assign h_last   = ({1'b0, h} == (h_tot - ONE));
  assign v_last   = ({1'b0, v} == (v_tot - ONE));
  assign hs_act   = ({1'b0, h} >= hs_beg) && ({1'b0, h} < hs_end);
  assign vs_act   = ({1'b0, v} >= vs_beg) && ({1'b0, v} < vs_end);
  assign blank_nx = (h >= act_cfg.hact) || (v >= act_cfg.vact);

  // New timing is only swapped in on the last pixel of a frame, so the
  // following frame starts cleanly at (0,0) with the new geometry.
  assign apply = en && cfg_pending && h_last && v_last;

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      h            <= '0;
      v            <= '0;
      act_cfg      <= DEF_CFG;
      shd_cfg      <= DEF_CFG;
      cfg_pending  <= 1'b0;
      hs           <= ~DEF_HPOL;
      vs           <= ~DEF_VPOL;
      blank        <= 1'b1;
      de           <= 1'b0;
      hcount       <= '0;
      vcount       <= '0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      vblank_start <= 1'b0;
    end else begin
      if (cfg_load) begin
        shd_cfg     <= cfg_in;
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end

      if (apply) begin
        act_cfg <= shd_cfg;
      end

      if (en) begin
        h <= h_last ? '0 : h + CW'(1);
        if (h_last) begin
          v <= v_last ? '0 : v + CW'(1);
        end
        hs           <= hs_act ? act_cfg.hpol : ~act_cfg.hpol;
        vs           <= vs_act ? act_cfg.vpol : ~act_cfg.vpol;
        blank        <= blank_nx;
        de           <= ~blank_nx;
        hcount       <= h;
        vcount       <= v;
        line_start   <= (h == '0);
        frame_start  <= (h == '0) && (v == '0);
        vblank_start <= (h == '0) && (v == act_cfg.vact);
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  localparam int CW = 11;
  // Short vertical default keeps a full default frame at 800x10 cycles.
  localparam int TB_VACT  = 4;
  localparam int TB_VFP   = 2;
  localparam int TB_VSYNC = 2;
  localparam int TB_VBP   = 2;

  logic          pixel_clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] cfg_hact, cfg_hfp, cfg_hsync, cfg_hbp;
  logic [CW-1:0] cfg_vact, cfg_vfp, cfg_vsync, cfg_vbp;
  logic          cfg_hpol, cfg_vpol, cfg_load;
  logic          cfg_pending, hs, vs, blank, de;
  logic [CW-1:0] hcount, vcount;
  logic          line_start, frame_start, vblank_start;

  int checks = 0;
  int errors = 0;

  vga_timing_gen #(
    .CW(CW), .DEF_VACT(TB_VACT), .DEF_VFP(TB_VFP),
    .DEF_VSYNC(TB_VSYNC), .DEF_VBP(TB_VBP)
  ) dut (
    .pixel_clk(pixel_clk), .rst(rst), .en(en),
    .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp), .cfg_hsync(cfg_hsync), .cfg_hbp(cfg_hbp),
    .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp), .cfg_vsync(cfg_vsync), .cfg_vbp(cfg_vbp),
    .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_load(cfg_load),
    .cfg_pending(cfg_pending), .hs(hs), .vs(vs), .blank(blank), .de(de),
    .hcount(hcount), .vcount(vcount), .line_start(line_start),
    .frame_start(frame_start), .vblank_start(vblank_start)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pixel_clk);
  endtask

  task automatic set_cfg(input int ha, hf, hsy, hb, va, vf, vsy, vb, input logic hp, vp);
    cfg_hact = CW'(ha);  cfg_hfp = CW'(hf);  cfg_hsync = CW'(hsy); cfg_hbp = CW'(hb);
    cfg_vact = CW'(va);  cfg_vfp = CW'(vf);  cfg_vsync = CW'(vsy); cfg_vbp = CW'(vb);
    cfg_hpol = hp;       cfg_vpol = vp;
  endtask

  task automatic load_pulse();
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  // Waits for the next frame_start, then profiles exactly one frame.
  task automatic measure_frame(input string tag, input logic hp, input logic vp,
                               input int e_len, input int e_de, input int e_hmin,
                               input int e_hmax, input int e_hcnt, input int e_vmin,
                               input int e_vmax, input int e_lines, input int e_lp,
                               input int e_vact, input logic e_pend);
    int t, len, de_cnt, hmin, hmax, hcnt, vmin, vmax, lines, ls0, ls1, bad;
    t = 0;
    do begin step(); t++; end while (!frame_start && t < 20000);
    check({tag, ".fs_seen"}, frame_start, 1);
    check({tag, ".pend"}, cfg_pending, e_pend);
    len = 0; de_cnt = 0; hcnt = 0; lines = 0; bad = 0;
    hmin = 32'hFFFF; hmax = 0; vmin = 32'hFFFF; vmax = 0; ls0 = -1; ls1 = -1;
    do begin
      if (de) de_cnt++;
      if (hs == hp) begin
        hcnt++;
        if (int'(hcount) < hmin) hmin = int'(hcount);
        if (int'(hcount) > hmax) hmax = int'(hcount);
      end
      if (vs == vp) begin
        if (int'(vcount) < vmin) vmin = int'(vcount);
        if (int'(vcount) > vmax) vmax = int'(vcount);
      end
      if (line_start) begin
        lines++;
        if (ls0 < 0) ls0 = len;
        else if (ls1 < 0) ls1 = len;
      end
      if (line_start !== (hcount == 0)) bad++;
      if (frame_start !== (hcount == 0 && vcount == 0)) bad++;
      if (vblank_start !== (hcount == 0 && int'(vcount) == e_vact)) bad++;
      if (de === blank) bad++;
      step();
      len++;
    end while (!frame_start && len < 20000);
    check({tag, ".frame_len"}, len, e_len);
    check({tag, ".de_cnt"}, de_cnt, e_de);
    check({tag, ".hs_min"}, hmin, e_hmin);
    check({tag, ".hs_max"}, hmax, e_hmax);
    check({tag, ".hs_cnt"}, hcnt, e_hcnt);
    check({tag, ".vs_min"}, vmin, e_vmin);
    check({tag, ".vs_max"}, vmax, e_vmax);
    check({tag, ".lines"}, lines, e_lines);
    check({tag, ".line_period"}, ls1 - ls0, e_lp);
    check({tag, ".strobe_align"}, bad, 0);
  endtask

  initial begin
    int t, glitch, froze, seq, ls_cnt;
    logic [2*CW+9:0] snap;
    logic [CW-1:0]   prev_h;

    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(); step();
    check("rst.hs", hs, 1);
    check("rst.vs", vs, 1);
    check("rst.blank", blank, 1);
    check("rst.de", de, 0);
    check("rst.hcount", hcount, 0);
    check("rst.vcount", vcount, 0);
    check("rst.strobes", {line_start, frame_start, vblank_start}, 0);
    check("rst.pend", cfg_pending, 0);

    // Default mode
    rst = 1'b0; en = 1'b1;
    measure_frame("def", 1'b0, 1'b0, 8000, 2560, 656, 751, 960, 6, 7, 10, 800, 4, 1'b0);

    // Tiny mode loaded mid-frame
    repeat (100) step();
    set_cfg(4, 1, 1, 2, 2, 1, 1, 1, 1'b0, 1'b0);
    load_pulse();
    check("tiny.pend_set", cfg_pending, 1);
    t = 0;
    while (cfg_pending && t < 10000) begin step(); t++; end
    check("tiny.pend_clr", cfg_pending, 0);
    check("tiny.apply_h", hcount, 799);
    check("tiny.apply_v", vcount, 9);
    measure_frame("tiny", 1'b0, 1'b0, 40, 8, 5, 5, 5, 3, 3, 5, 8, 2, 1'b0);

    // Polarity flip in tiny mode
    repeat (10) step();
    set_cfg(4, 1, 1, 2, 2, 1, 1, 1, 1'b1, 1'b1);
    load_pulse();
    glitch = 0; t = 0;
    while (cfg_pending && t < 200) begin
      if (hs !== !(hcount == 5)) glitch++;
      if (vs !== !(vcount == 3)) glitch++;
      step(); t++;
    end
    check("pol.pend_clr", cfg_pending, 0);
    check("pol.no_glitch", glitch, 0);
    check("pol.hs_old_at_apply", hs, 1);
    step();
    check("pol.h0", hcount, 0);
    check("pol.hs_new", hs, 0);
    check("pol.vs_new", vs, 0);
    measure_frame("pol", 1'b1, 1'b1, 40, 8, 5, 5, 5, 3, 3, 5, 8, 2, 1'b0);

    // Pause mid-line
    t = 0;
    while (hcount != 3 && t < 100) begin step(); t++; end
    check("en.reach_h3", hcount, 3);
    snap = {hs, vs, blank, de, hcount, vcount, line_start, frame_start, vblank_start, cfg_pending};
    en = 1'b0;
    froze = 0;
    repeat (7) begin
      step();
      if ({hs, vs, blank, de, hcount, vcount, line_start, frame_start, vblank_start, cfg_pending} !== snap)
        froze++;
    end
    check("en.frozen", froze, 0);
    en = 1'b1;
    step();
    check("en.resume_h", hcount, 4);
    seq = 0; ls_cnt = 0;
    repeat (16) begin
      prev_h = hcount;
      step();
      if (hcount !== ((prev_h == 7) ? CW'(0) : prev_h + CW'(1))) seq++;
      if (line_start) ls_cnt++;
    end
    check("en.seq", seq, 0);
    check("en.ls_once", ls_cnt, 2);

    // Two loads in one frame, then a third on the apply edge
    t = 0;
    do begin step(); t++; end while (!frame_start && t < 100);
    repeat (3) step();
    set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
    load_pulse();
    step();
    set_cfg(4, 2, 1, 1, 2, 1, 2, 1, 1'b0, 1'b0);
    load_pulse();
    t = 0;
    while (!(hcount == 6 && vcount == 4) && t < 100) begin step(); t++; end
    check("ld.reach_edge", {hcount, vcount}, {CW'(6), CW'(4)});
    set_cfg(3, 1, 1, 1, 2, 1, 1, 1, 1'b1, 1'b0);
    load_pulse();
    check("ld.pend_kept", cfg_pending, 1);
    check("ld.edge_h", hcount, 7);
    measure_frame("ldB", 1'b0, 1'b0, 48, 8, 6, 6, 6, 3, 4, 6, 8, 2, 1'b1);
    measure_frame("ldC", 1'b1, 1'b0, 30, 6, 4, 4, 5, 3, 3, 5, 6, 2, 1'b0);

    // Reset mid-frame discards the pending shadow
    set_cfg(640, 16, 96, 48, 4, 2, 2, 2, 1'b0, 1'b0);
    load_pulse();
    t = 0;
    while (cfg_pending && t < 200) begin step(); t++; end
    check("rst6.def_applied", cfg_pending, 0);
    repeat (50) step();
    set_cfg(4, 1, 1, 2, 2, 1, 1, 1, 1'b1, 1'b1);
    load_pulse();
    t = 0;
    while (!(hcount == 300 && vcount == 2) && t < 10000) begin step(); t++; end
    check("rst6.reach", {hcount, vcount}, {CW'(300), CW'(2)});
    check("rst6.pend_before", cfg_pending, 1);
    rst = 1'b1;
    #1;
    check("rst6.hs", hs, 1);
    check("rst6.vs", vs, 1);
    check("rst6.blank_de", {blank, de}, 2'b10);
    check("rst6.counts", {hcount, vcount}, 0);
    check("rst6.strobes", {line_start, frame_start, vblank_start}, 0);
    check("rst6.pend", cfg_pending, 0);
    step(); step();
    rst = 1'b0;
    step();
    check("rst6.fs_first", frame_start, 1);
    check("rst6.fs_pos", {hcount, vcount}, 0);
    measure_frame("rst6", 1'b0, 1'b0, 8000, 2560, 656, 751, 960, 6, 7, 10, 800, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
